// File: rtl/mem_initiator_if.sv
// Signal bundle between the CPU datapath, the LC-3 memory initiator and the memory block.
// The master modport is the initiator's view; slave is the view of whoever drives requests and responses.
interface mem_initiator_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic        MEM_EN;
    logic        R_W;
    logic [15:0] a;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        R;

    modport master (
        input  req, we, addr, wdata, d_out, R,
        output ready, done, err, rdata, MEM_EN, R_W, a, d_in
    );

    modport slave (
        output req, we, addr, wdata, d_out, R,
        input  ready, done, err, rdata, MEM_EN, R_W, a, d_in
    );
endinterface

// File: rtl/mem_initiator.sv
// LC-3 memory bus initiator: one load/store at a time, one-cycle MEM_EN strobe,
// response timeout and optional write-echo check. All outputs are registered.
module mem_initiator #(
    parameter int TIMEOUT  = 15,
    parameter bit WR_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_initiator_if.master bus
);
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    state_t      r_state, w_state_next;
    logic        r_ready, w_ready;
    logic        r_done, w_done;
    logic        r_err, w_err;
    logic        r_mem_en, w_mem_en;
    logic        r_r_w, w_r_w;
    logic [15:0] r_a, w_a;
    logic [15:0] r_d_in, w_d_in;
    logic [15:0] r_rdata, w_rdata;
    logic [7:0]  r_cnt, w_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_en <= 1'b0;
            r_r_w    <= 1'b0;
            r_a      <= 16'h0000;
            r_d_in   <= 16'h0000;
            r_rdata  <= 16'h0000;
            r_cnt    <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_ready  <= w_ready;
            r_done   <= w_done;
            r_err    <= w_err;
            r_mem_en <= w_mem_en;
            r_r_w    <= w_r_w;
            r_a      <= w_a;
            r_d_in   <= w_d_in;
            r_rdata  <= w_rdata;
            r_cnt    <= w_cnt;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = r_ready;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_mem_en     = 1'b0;
        w_r_w        = r_r_w;
        w_a          = r_a;
        w_d_in       = r_d_in;
        w_rdata      = r_rdata;
        w_cnt        = r_cnt;

        case (r_state)
            IDLE: begin
                // R arriving here is stale or spurious and is deliberately not looked at.
                w_ready = 1'b1;
                if (bus.req) begin
                    w_r_w        = bus.we;
                    w_a          = bus.addr;
                    w_d_in       = bus.wdata;
                    w_mem_en     = 1'b1;
                    w_ready      = 1'b0;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_cnt        = 8'h00;
                w_state_next = WAIT;
            end
            WAIT: begin
                // A response on the final timeout edge still counts as a success.
                if (bus.R) begin
                    if (!r_r_w) begin
                        w_rdata = bus.d_out;
                    end else if (WR_CHECK && (bus.d_out != r_d_in)) begin
                        w_err = 1'b1;
                    end
                    w_done       = 1'b1;
                    w_ready      = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt >= TIMEOUT_W) begin
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                    w_ready      = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt = r_cnt + 8'h01;
                end
            end
            default: begin
                w_ready      = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.ready  = r_ready;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.rdata  = r_rdata;
    assign bus.MEM_EN = r_mem_en;
    assign bus.R_W    = r_r_w;
    assign bus.a      = r_a;
    assign bus.d_in   = r_d_in;
endmodule

// File: tb/tb_mem_initiator.sv
// Testbench for mem_initiator: randomized loads/stores against a memory responder,
// checked by a scoreboard fed from a reference memory model.
`timescale 1ns/1ps
module tb_mem_initiator;
    localparam int T  = 15;
    localparam int T2 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_initiator_if bus ();
    mem_initiator_if bus2 ();

    mem_initiator #(.TIMEOUT(T), .WR_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mem_initiator #(.TIMEOUT(T2), .WR_CHECK(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference memory: unwritten words read back as a fixed function of the address.
    function automatic logic [15:0] dflt(input logic [15:0] ad);
        return ad ^ 16'h5A5A;
    endfunction

    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_rdata = 16'h0000;

    function automatic logic [15:0] ref_rd(input logic [15:0] ad);
        return ref_mem.exists(ad) ? ref_mem[ad] : dflt(ad);
    endfunction

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          at;
    } exp_t;
    exp_t sbq[$];

    // Memory device model for the main DUT; delay 0 means it never answers.
    logic [15:0] mem_dev [logic [15:0]];
    int          cur_delay   = 1;
    bit          cur_corrupt = 1'b0;
    bit          spur        = 1'b0;

    initial begin
        int          left;
        bit          pend;
        bit          cap_we;
        bit          cap_cor;
        logic [15:0] cap_a;
        logic [15:0] cap_d;
        left = 0; pend = 1'b0; cap_we = 1'b0; cap_cor = 1'b0; cap_a = '0; cap_d = '0;
        bus.R = 1'b0;
        bus.d_out = 16'h0000;
        forever begin
            @(negedge clk);
            bus.R = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                left--;
                if (left == 0) begin
                    pend  = 1'b0;
                    bus.R = 1'b1;
                    if (cap_we) begin
                        mem_dev[cap_a] = cap_d;
                        bus.d_out = cap_cor ? (cap_d ^ 16'h0001) : cap_d;
                    end else begin
                        bus.d_out = mem_dev.exists(cap_a) ? mem_dev[cap_a] : dflt(cap_a);
                    end
                end
            end else if (bus.MEM_EN) begin
                cap_we  = bus.R_W;
                cap_a   = bus.a;
                cap_d   = bus.d_in;
                cap_cor = cur_corrupt;
                left    = cur_delay;
                pend    = (cur_delay > 0);
            end else if (spur) begin
                spur      = 1'b0;
                bus.R     = 1'b1;
                bus.d_out = 16'($urandom);
            end
        end
    end

    // Second DUT's responder: answers one cycle after MEM_EN, echo always off by one bit.
    bit resp2_en = 1'b1;
    initial begin
        bit seen2;
        seen2 = 1'b0;
        bus2.R = 1'b0;
        bus2.d_out = 16'h0000;
        forever begin
            @(negedge clk);
            bus2.R = 1'b0;
            if (seen2) begin
                bus2.R     = 1'b1;
                bus2.d_out = bus2.R_W ? (bus2.d_in ^ 16'h0001) : 16'hBEEF;
            end
            seen2 = bus2.MEM_EN && resp2_en;
        end
    end

    // Monitor: every done pulse is matched against the oldest expected completion.
    initial begin
        logic prev_done;
        logic prev_mem_en;
        exp_t e;
        prev_done = 1'b0;
        prev_mem_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.done) begin
                    check("done_one_cycle", prev_done, 1'b0);
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=done required=no_done (t=%0t)", $time);
                    end else begin
                        e = sbq.pop_front();
                        check("done_err", bus.err, e.err);
                        check("done_rdata", bus.rdata, e.rdata);
                        check("done_cycle", cyc, e.at);
                    end
                end
                if (bus.MEM_EN) check("mem_en_one_cycle", prev_mem_en, 1'b0);
            end
            prev_done   = bus.done;
            prev_mem_en = bus.MEM_EN;
        end
    end

    task automatic wait_ready1();
        int n;
        n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.ready, 1'b1);
    endtask

    task automatic issue(input bit w, input logic [15:0] ad, input logic [15:0] wd,
                         input int dly, input bit cor);
        int   c;
        exp_t e;
        wait_ready1();
        cur_delay   = dly;
        cur_corrupt = cor;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = ad;
        bus.wdata = wd;
        c = cyc;
        // Done lands d+1 edges after the request edge, or TIMEOUT+2 when memory stays silent.
        if (dly == 0) begin
            e.err   = 1'b1;
            e.rdata = exp_rdata;
            e.at    = c + T + 3;
        end else begin
            e.at = c + dly + 2;
            if (w) begin
                ref_mem[ad] = wd;
                e.err   = cor;
                e.rdata = exp_rdata;
            end else begin
                exp_rdata = ref_rd(ad);
                e.err   = 1'b0;
                e.rdata = exp_rdata;
            end
        end
        sbq.push_back(e);
        @(negedge clk);
        bus.req = 1'b0;
        check("access_mem_en", bus.MEM_EN, 1'b1);
        check("access_a", bus.a, ad);
        check("access_r_w", bus.R_W, w);
        check("access_d_in", bus.d_in, wd);
        check("access_ready", bus.ready, 1'b0);
        @(negedge clk);
        check("wait_mem_en", bus.MEM_EN, 1'b0);
    endtask

    task automatic run2(input bit w, input logic [15:0] wd, input bit en,
                        input logic exp_err, input logic [15:0] exp_rd, input int exp_lat);
        int n;
        n = 0;
        while (!bus2.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("dut2_ready", bus2.ready, 1'b1);
        resp2_en   = en;
        bus2.req   = 1'b1;
        bus2.we    = w;
        bus2.addr  = 16'h7000;
        bus2.wdata = wd;
        @(negedge clk);
        bus2.req = 1'b0;
        n = 1;
        while (!bus2.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("dut2_latency", n, exp_lat);
        check("dut2_err", bus2.err, exp_err);
        check("dut2_rdata", bus2.rdata, exp_rd);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.req = 1'b0;  bus.we = 1'b0;  bus.addr = '0;  bus.wdata = '0;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready, 1'b1);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_mem_en", bus.MEM_EN, 1'b0);
        check("rst_r_w", bus.R_W, 1'b0);
        check("rst_a", bus.a, 16'h0000);
        check("rst_d_in", bus.d_in, 16'h0000);
        check("rst_rdata", bus.rdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        mem_dev[16'h3000] = 16'h1234;
        ref_mem[16'h3000] = 16'h1234;
        issue(1'b0, 16'h3000, 16'h0000, 1, 1'b0);
        issue(1'b1, 16'h4000, 16'hABCD, 1, 1'b0);
        issue(1'b0, 16'h4000, 16'h0000, 1, 1'b0);
        issue(1'b0, 16'h4000, 16'h0000, 0, 1'b0);
        issue(1'b0, 16'h3000, 16'h0000, T + 1, 1'b0);
        issue(1'b1, 16'h3004, 16'h5555, 1, 1'b1);
        issue(1'b1, 16'h3005, 16'h0F0F, 0, 1'b0);

        // A request pulsed mid-access must vanish without a trace.
        issue(1'b0, 16'h3000, 16'h0000, 5, 1'b0);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h5000; bus.wdata = 16'hDEAD;
        @(negedge clk);
        bus.req = 1'b0;
        check("drop_a_held", bus.a, 16'h3000);
        check("drop_r_w_held", bus.R_W, 1'b0);
        check("drop_mem_en", bus.MEM_EN, 1'b0);
        issue(1'b0, 16'h5000, 16'h0000, 1, 1'b0);

        for (int i = 0; i < 120; i++) begin
            bit          w;
            bit          cor;
            int          dly;
            logic [15:0] ad;
            logic [15:0] wd;
            w  = 1'($urandom_range(0, 1));
            ad = 16'h3000 + 16'($urandom_range(0, 7));
            wd = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       dly = 0;
                1, 2:    dly = $urandom_range(2, T + 1);
                default: dly = 1;
            endcase
            cor = w && ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) begin
                wait_ready1();
                spur = 1'b1;
                @(negedge clk);
                @(negedge clk);
            end
            issue(w, ad, wd, dly, cor);
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sbq.size(), 0);

        // Reset while MEM_EN is high: it must drop with no clock edge.
        wait_ready1();
        cur_delay = 0;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h6000;
        @(negedge clk);
        bus.req = 1'b0;
        check("rst_access_mem_en_before", bus.MEM_EN, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_access_mem_en", bus.MEM_EN, 1'b0);
        check("rst_access_ready", bus.ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 16'h0000;
        check("rst_access_rdata", bus.rdata, 16'h0000);

        // Reset while waiting for R.
        wait_ready1();
        cur_delay = 0;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h6100; bus.wdata = 16'h1111;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("rst_wait_ready_before", bus.ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_wait_ready", bus.ready, 1'b1);
        check("rst_wait_mem_en", bus.MEM_EN, 1'b0);
        check("rst_wait_a", bus.a, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (T + 8) @(negedge clk);
        issue(1'b0, 16'h3001, 16'h0000, 1, 1'b0);
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained_after_reset", sbq.size(), 0);

        // Echo checking disabled: a corrupted echo is not an error.
        run2(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000, 3);
        run2(1'b0, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 3);
        run2(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, T2 + 3);
        run2(1'b1, 16'h1234, 1'b0, 1'b1, 16'hBEEF, T2 + 3);
        run2(1'b1, 16'h00FF, 1'b1, 1'b0, 16'hBEEF, 3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
